// File: rtl/ram_arbiter_if.sv
// Request/response and RAM-side bundle shared by the two requesters and the
// single-ported RAM around ram_arbiter.
interface ram_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 4
);
    logic          a_req;
    logic          a_rwn;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic          a_ack;
    logic [DW-1:0] a_dout;

    logic          b_req;
    logic          b_rwn;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din;
    logic          b_ack;
    logic [DW-1:0] b_dout;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_rwn;
    logic          ram_csn;
    logic [DW-1:0] ram_dout;
    logic          busy;

    modport slave (
        input  a_req, a_rwn, a_addr, a_din,
        output a_ack, a_dout,
        input  b_req, b_rwn, b_addr, b_din,
        output b_ack, b_dout,
        output ram_addr, ram_din, ram_rwn, ram_csn,
        input  ram_dout,
        output busy
    );

    modport master (
        output a_req, a_rwn, a_addr, a_din,
        input  a_ack, a_dout,
        output b_req, b_rwn, b_addr, b_din,
        input  b_ack, b_dout,
        input  ram_addr, ram_din, ram_rwn, ram_csn,
        output ram_dout,
        input  busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for an asynchronous single-ported RAM; all RAM
// controls registered. Define RAM_ARB_RR_EN for round-robin, else A has priority.
module ram_arbiter #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input logic          clk,
    input logic          rstn,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_q;
    logic          owner_q;     // 1 = port B owns the current access
    logic          csn_q;
    logic          rwn_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic          a_ack_q;
    logic          b_ack_q;
    logic [DW-1:0] a_dout_q;
    logic [DW-1:0] b_dout_q;
    logic          busy_q;
    logic          any_req;
    logic          grant_b_d;

    assign any_req = bus.a_req | bus.b_req;

`ifdef RAM_ARB_RR_EN
    logic ptr_q;                // 1 = B preferred on a tie

    always_comb grant_b_d = bus.b_req & (~bus.a_req | ptr_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ptr_q <= 1'b0;
        else if (state_q == IDLE && any_req)
            ptr_q <= ~grant_b_d;
    end
`else
    always_comb grant_b_d = bus.b_req & ~bus.a_req;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            csn_q    <= 1'b1;
            rwn_q    <= 1'b1;
            addr_q   <= '0;
            din_q    <= '0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            a_dout_q <= '0;
            b_dout_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= grant_b_d;
                        addr_q  <= grant_b_d ? bus.b_addr : bus.a_addr;
                        din_q   <= grant_b_d ? bus.b_din  : bus.a_din;
                        rwn_q   <= grant_b_d ? bus.b_rwn  : bus.a_rwn;
                        csn_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // RAM has had a full cycle since addr/csn settled
                    if (rwn_q) begin
                        if (owner_q) b_dout_q <= bus.ram_dout;
                        else         a_dout_q <= bus.ram_dout;
                    end
                    a_ack_q <= ~owner_q;
                    b_ack_q <= owner_q;
                    csn_q   <= 1'b1;
                    rwn_q   <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    // requests ignored here so a held req is not double-served
                    a_ack_q <= 1'b0;
                    b_ack_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ram_csn  = csn_q;
    assign bus.ram_rwn  = rwn_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_din  = din_q;
    assign bus.a_ack    = a_ack_q;
    assign bus.b_ack    = b_ack_q;
    assign bus.a_dout   = a_dout_q;
    assign bus.b_dout   = b_dout_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural asynchronous RAM.
module tb_ram_arbiter;
    localparam int AW = 4;
    localparam int DW = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus();
    ram_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    logic [DW-1:0] mem     [2**AW];
    logic [DW-1:0] ref_mem [2**AW];

    assign bus.ram_dout = mem[bus.ram_addr];
    always @(posedge clk)
        if (!bus.ram_csn && !bus.ram_rwn) mem[bus.ram_addr] <= bus.ram_din;

    typedef struct {
        logic          port;   // 1 = B
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // ack monitor: order, read data, exclusivity, no back-to-back acks
    logic prev_a = 1'b0, prev_b = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_a = 1'b0;
            prev_b = 1'b0;
        end else begin
            if (bus.a_ack || bus.b_ack) begin
                exp_t e;
                chk("one_ack", {31'd0, bus.a_ack & bus.b_ack}, 0);
                if (bus.a_ack) chk("a_ack_gap", {31'd0, prev_a}, 0);
                if (bus.b_ack) chk("b_ack_gap", {31'd0, prev_b}, 0);
                chk("sb_pending", {31'd0, sb.size() != 0}, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("ack_port", {31'd0, bus.b_ack}, {31'd0, e.port});
                    if (e.rd)
                        chk(e.port ? "b_rd_data" : "a_rd_data",
                            e.port ? bus.b_dout : bus.a_dout, e.data);
                end
            end
            prev_a = bus.a_ack;
            prev_b = bus.b_ack;
        end
    end

    task automatic drive(input logic port, input logic req, input logic rd,
                         input logic [AW-1:0] addr, input logic [DW-1:0] din);
        if (port) begin
            bus.b_req = req; bus.b_rwn = rd; bus.b_addr = addr; bus.b_din = din;
        end else begin
            bus.a_req = req; bus.a_rwn = rd; bus.a_addr = addr; bus.a_din = din;
        end
    endtask

    function automatic exp_t expect_op(input logic port, input logic rd,
                                       input logic [AW-1:0] addr, input logic [DW-1:0] din);
        exp_t e;
        e.port = port;
        e.rd   = rd;
        e.data = rd ? ref_mem[addr] : din;
        if (!rd) ref_mem[addr] = din;
        return e;
    endfunction

    // issue one access from a negedge, wait (bounded) for its ack, drop req
    task automatic access(input logic port, input logic rd,
                          input logic [AW-1:0] addr, input logic [DW-1:0] din);
        logic got;
        sb.push_back(expect_op(port, rd, addr, din));
        drive(port, 1'b1, rd, addr, din);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (port ? bus.b_ack : bus.a_ack) got = 1'b1;
        end
        drive(port, 1'b0, 1'b1, addr, din);
        chk("ack_seen", {31'd0, got}, 1);
    endtask

    initial begin
        int n;
        logic [1:0] ord [4];
        for (int i = 0; i < 2**AW; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        drive(1'b0, 1'b0, 1'b1, '0, '0);
        drive(1'b1, 1'b0, 1'b1, '0, '0);

        // reset values
        #2 rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_csn",  {31'd0, bus.ram_csn}, 1);
        chk("rst_rwn",  {31'd0, bus.ram_rwn}, 1);
        chk("rst_addr", {28'd0, bus.ram_addr}, 0);
        chk("rst_ack",  {30'd0, bus.a_ack, bus.b_ack}, 0);
        chk("rst_dout", {24'd0, bus.a_dout, bus.b_dout}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // A write addr=3 din=4 with cycle-exact timing
        sb.push_back(expect_op(1'b0, 1'b0, 4'd3, 4'd4));
        drive(1'b0, 1'b1, 1'b0, 4'd3, 4'd4);
        @(posedge clk); #1;
        chk("wr_csn",  {31'd0, bus.ram_csn}, 0);
        chk("wr_rwn",  {31'd0, bus.ram_rwn}, 0);
        chk("wr_addr", {28'd0, bus.ram_addr}, 3);
        chk("wr_din",  {28'd0, bus.ram_din}, 4);
        chk("wr_busy", {31'd0, bus.busy}, 1);
        chk("wr_noack", {31'd0, bus.a_ack}, 0);
        @(posedge clk); #1;
        chk("wr_ack",   {31'd0, bus.a_ack}, 1);
        chk("wr_csn_hi", {31'd0, bus.ram_csn}, 1);
        drive(1'b0, 1'b0, 1'b1, 4'd3, 4'd4);
        @(posedge clk); #1;
        chk("wr_ack_lo", {31'd0, bus.a_ack}, 0);
        chk("wr_idle",   {31'd0, bus.busy}, 0);
        @(negedge clk);

        access(1'b0, 1'b1, 4'd3, '0);

        // B fills 0..3, A reads back
        for (int i = 0; i < 4; i++) access(1'b1, 1'b0, AW'(i), DW'(i + 1));
        for (int i = 0; i < 4; i++) access(1'b0, 1'b1, AW'(i), '0);
        chk("b_dout_kept", {28'd0, bus.b_dout}, 0);

        // reset in the middle of a write
        access(1'b0, 1'b0, 4'd5, 4'd6);
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 4'd5, 4'd9);
        @(posedge clk); #1;
        chk("abort_sel", {31'd0, bus.ram_csn}, 0);
        rstn = 1'b0;
        #1;
        chk("abort_csn",  {31'd0, bus.ram_csn}, 1);
        chk("abort_rwn",  {31'd0, bus.ram_rwn}, 1);
        chk("abort_addr", {28'd0, bus.ram_addr}, 0);
        chk("abort_ack",  {31'd0, bus.a_ack}, 0);
        chk("abort_busy", {31'd0, bus.busy}, 0);
        drive(1'b0, 1'b0, 1'b1, 4'd5, 4'd9);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        access(1'b0, 1'b1, 4'd5, '0);
        repeat (2) @(negedge clk);

        // A holds req through DONE: one ack per 3 cycles
        for (int i = 0; i < 4; i++) sb.push_back(expect_op(1'b0, 1'b1, 4'd3, '0));
        drive(1'b0, 1'b1, 1'b1, 4'd3, '0);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.a_ack) n++;
        end
        drive(1'b0, 1'b0, 1'b1, 4'd3, '0);
        chk("hold_acks", n, 4);
        repeat (3) @(negedge clk);

        // simultaneous requests from a fresh pointer
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
`ifdef RAM_ARB_RR_EN
        ord = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
        ord = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
        for (int i = 0; i < 4; i++)
            sb.push_back(ord[i][0] ? expect_op(1'b1, 1'b1, 4'd1, '0)
                                   : expect_op(1'b0, 1'b1, 4'd3, '0));
        drive(1'b0, 1'b1, 1'b1, 4'd3, '0);
        drive(1'b1, 1'b1, 1'b1, 4'd1, '0);
        n = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            if (bus.a_ack || bus.b_ack) n++;
        end
        drive(1'b0, 1'b0, 1'b1, 4'd3, '0);
        chk("simul_acks", n, 4);
`ifndef RAM_ARB_RR_EN
        // B was starved; it is served once A lets go
        sb.push_back(expect_op(1'b1, 1'b1, 4'd1, '0));
        n = 0;
        for (int c = 0; c < 10 && n < 1; c++) begin
            @(negedge clk);
            if (bus.b_ack) n++;
        end
        chk("b_after_a", n, 1);
`endif
        drive(1'b1, 1'b0, 1'b1, 4'd1, '0);
        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the single-ported asynchronous `ram` of the simple microprocessor. It lets two requesters share the RAM: port A (CPU datapath) and port B (program loader / debug). It serialises their accesses into clean csn/rwn cycles and returns read data with a one-cycle acknowledge. Every RAM control output is registered, so the RAM never sees combinational glitches from requester logic.

## Interface
- `AW`, 4, RAM address width
- `DW`, 4, RAM data width
- `clk` in 1: system clock; all state changes on its rising edge
- `rstn` in 1: reset, asynchronous, active-low
- `a_req` in 1: port A access request; level, held until `a_ack`
- `a_rwn` in 1: port A direction; 1 = read, 0 = write
- `a_addr` in AW: port A address
- `a_din` in DW: port A write data
- `a_ack` out 1: port A one-cycle completion pulse
- `a_dout` out DW: port A read data; valid from the `a_ack` cycle, held until the next A read completes
- `b_req`, `b_rwn`, `b_addr`, `b_din`, `b_ack`, `b_dout`: identical set for port B
- `ram_addr` out AW: to RAM `addr`
- `ram_din` out DW: to RAM `din`
- `ram_rwn` out 1: to RAM `rwn`
- `ram_csn` out 1: to RAM `csn`
- `ram_dout` in DW: from RAM `dout`
- `busy` out 1: high while state ≠ IDLE

## Operation
- FSM states: IDLE → ACCESS → DONE → IDLE.
- **IDLE**
  - If any req is high, select the winner and latch owner.
  - Register the owner's addr/din/rwn onto `ram_*` and set `ram_csn`=0.
  - Go to ACCESS.
- **ACCESS**
  - RAM is selected for exactly one cycle.
  - On the next edge: if read, capture `ram_dout` into the owner's `*_dout`.
  - Pulse the owner's `*_ack`=1, set `ram_csn`=1 and `ram_rwn`=1, go to DONE.
  - A write is therefore presented with csn=0 and rwn=0 for exactly one cycle.
- **DONE**
  - Drive `*_ack`=0 and go to IDLE.
  - Any req is ignored here; this gives the requester one cycle to drop or update its req after the ack.
- **Request rules**
  - A requester must hold req, rwn, addr and din stable from assertion until its ack.
  - A req still high in IDLE after DONE is treated as a new access.
- **Arbitration:** see Configuration. A lone requester always wins.
- `ram_addr`/`ram_din` keep their last values when csn=1; they return to 0 only on reset.
- **Reset** (asynchronous, any state, including mid-write in ACCESS):
  - Immediately `ram_csn`=1, `ram_rwn`=1, `ram_addr`=0, `ram_din`=0.
  - `a_ack`=`b_ack`=0, `a_dout`=`b_dout`=0, `busy`=0.
  - State IDLE; round-robin pointer prefers A.
  - An aborted access is not acked and must be reissued.

## Timing
- Req sampled high at edge N:
  - `ram_csn` low during cycle N..N+1.
  - `*_ack` high during cycle N+1..N+2.
  - IDLE again at edge N+2.
- Throughput: one access per 3 clocks. Back-to-back holding requesters alternate (RR) every 3 cycles.
- Read data: `ram_dout` sampled at edge N+1, i.e. one full cycle after csn/addr change, and visible on `*_dout` together with ack.
- Both ports' ack are never high in the same cycle.

## Configuration
- `RAM_ARB_RR_EN`
  - **Defined:** round-robin. A 1-bit pointer flips to the other port after each granted access. On a simultaneous request, the pointed-to port wins.
  - **Undefined:** fixed priority; port A always wins a simultaneous request. Port B can starve while A holds req; the pointer logic is not built.

## Test plan
- **Reset values:** hold rstn=0 → `ram_csn`=1, `ram_rwn`=1, `ram_addr`=0, both ack=0, both dout=0, `busy`=0.
- **A write then read:**
  - A writes addr=3, din=4 → one cycle with csn=0, rwn=0, addr=3, din=4, then `a_ack` pulse 2 edges after req.
  - A then reads addr=3 → `a_dout`=4 with `a_ack`.
- **B fills, A reads:** B writes addr 0..3 with 1..4, then A reads addr 0..3 → `a_dout`=1,2,3,4, and `b_dout` is unchanged at 0.
- **Simultaneous requests:**
  - Both req at the same edge, held for 4 accesses.
  - With `RAM_ARB_RR_EN` → ack order A,B,A,B.
  - Without it → A,A,A,A while B waits.
- **Reset mid-write:** pull rstn low during ACCESS of an A write to addr=5 → csn=1 at once, no `a_ack`. After release, a read of addr=5 is served normally with no stale ack.
- **Hold-after-ack:** A keeps req high through DONE → exactly one ack per 3 cycles, never two consecutive ack cycles.
